// File: rtl/funct_generator_nco.sv
// ---------------------------------------------------------------------------
// funct_generator_nco
//
// Multi-channel numerically controlled function generator. Every channel has
// its own phase accumulator, waveform select and signed amplitude. Channels
// are served round-robin through one shared two-stage waveform/scale
// pipeline, and the tagged samples are pushed into a downstream FIFO. The
// FIFO full flag stalls the whole datapath, so no sample is lost or repeated.
//
// Optional feature (compile-time macro FGEN_PHASE_OFS_EN):
//   defined   -> adds phase_ofs_i, a per-channel phase offset latched on a
//                configuration and added to the phase before LUT addressing.
//   undefined -> no offset port or registers (offset is effectively 0).
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   en_low_i     active-low run request
//   enh_conf_i   configuration strobe (IDLE -> CONFI)
//   ch_sel_i     channel written during CONFI (values >= NUM_CH ignored)
//   sel_i        waveform: 0 sine, 1 cosine, 2 triangle, 3 square
//   amp_i        signed amplitude, Q1.(AMP_WIDTH-1)
//   step_i       phase increment per sample of the channel
//   phase_ofs_i  per-channel phase offset (FGEN_PHASE_OFS_EN only)
//   full_i       downstream FIFO full
//   wr_en_o      FIFO write strobe
//   data_o       signed sample
//   ch_o         channel tag of data_o
//
// Handshake: a sample is transferred exactly in a cycle where wr_en_o=1;
// wr_en_o is only raised while full_i=0, and while full_i=1 every pipeline
// register, phase and the round-robin pointer hold their value.
//
// Internal state for checkers: state_q (IDLE/CONFI/GEN), phase_q[],
// sel_q[], amp_q[], step_q[].
// ---------------------------------------------------------------------------
module funct_generator_nco #(
  parameter int DATA_WIDTH  = 16,
  parameter int LUT_ADDR    = 8,
  parameter int PHASE_WIDTH = 16,
  parameter int AMP_WIDTH   = 8,
  parameter int NUM_CH      = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_low_i,
  input  logic                          enh_conf_i,
  input  logic [CH_W-1:0]               ch_sel_i,
  input  logic [1:0]                    sel_i,
  input  logic signed [AMP_WIDTH-1:0]   amp_i,
  input  logic [PHASE_WIDTH-1:0]        step_i,
`ifdef FGEN_PHASE_OFS_EN
  input  logic [PHASE_WIDTH-1:0]        phase_ofs_i,
`endif
  input  logic                          full_i,
  output logic                          wr_en_o,
  output logic signed [DATA_WIDTH-1:0]  data_o,
  output logic [CH_W-1:0]               ch_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONFI = 2'd1,
    ST_GEN   = 2'd2
  } state_e;

  localparam int LUT_SIZE = 2 ** LUT_ADDR;
  localparam int PROD_W   = DATA_WIDTH + AMP_WIDTH;

  localparam longint MAX_L = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
  // pi/2 in Q30, used by the elaboration-time sine table generator.
  localparam longint PIO2_Q30 = 64'sd1686629713;

  localparam logic signed [DATA_WIDTH-1:0] WAVE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] WAVE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]        SIGN_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LUT_ADDR-1:0]          QTR_ADDR = LUT_ADDR'(2 ** (LUT_ADDR - 2));

  localparam logic signed [PROD_W-1:0] SAT_HI = {{(AMP_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_LO = {{(AMP_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Sine table: round(MAX * sin(2*pi*k/LUT_SIZE)), evaluated at elaboration
  // with integer Q30 arithmetic (quarter-wave fold + Taylor series) so the
  // table is a plain constant ROM.
  // -------------------------------------------------------------------------
  function automatic logic signed [DATA_WIDTH-1:0] sine_entry(input int k);
    longint n, idx, x, x2, term, sum, val;
    logic   neg;
    n   = longint'(1) <<< LUT_ADDR;
    idx = longint'(k);
    neg = (idx >= n / 2);
    if (neg) idx = idx - n / 2;
    if (idx > n / 4) idx = n / 2 - idx;
    x    = (idx * PIO2_Q30 * 4 + n / 2) / n;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int i = 1; i < 12; i++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1)));
      sum  = sum + term;
    end
    val = (MAX_L * sum + (longint'(1) <<< 29)) >>> 30;
    if (val > MAX_L) val = MAX_L;
    if (val < 0)     val = 0;
    if (neg)         val = -val;
    return val[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] sine_lut [LUT_SIZE];

  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
    localparam logic signed [DATA_WIDTH-1:0] LUT_VAL = sine_entry(k);
    assign sine_lut[k] = LUT_VAL;
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                        state_q, state_d;
  logic [CH_W-1:0]               ptr_q, ptr_d;
  logic [PHASE_WIDTH-1:0]        phase_q [NUM_CH];
  logic [PHASE_WIDTH-1:0]        phase_d [NUM_CH];
  logic [1:0]                    sel_q   [NUM_CH];
  logic [1:0]                    sel_d   [NUM_CH];
  logic signed [AMP_WIDTH-1:0]   amp_q   [NUM_CH];
  logic signed [AMP_WIDTH-1:0]   amp_d   [NUM_CH];
  logic [PHASE_WIDTH-1:0]        step_q  [NUM_CH];
  logic [PHASE_WIDTH-1:0]        step_d  [NUM_CH];
`ifdef FGEN_PHASE_OFS_EN
  logic [PHASE_WIDTH-1:0]        ofs_q   [NUM_CH];
  logic [PHASE_WIDTH-1:0]        ofs_d   [NUM_CH];
`endif

  logic                          s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH-1:0]  s1_wave_q, s1_wave_d;
  logic [CH_W-1:0]               s1_ch_q, s1_ch_d;
  logic                          s2_valid_q, s2_valid_d;
  logic signed [DATA_WIDTH-1:0]  s2_data_q, s2_data_d;
  logic [CH_W-1:0]               s2_ch_q, s2_ch_d;

  logic                          in_gen;
  logic                          issue;
  logic                          cfg_wr;

  logic [PHASE_WIDTH-1:0]        cur_phase;
  logic [PHASE_WIDTH-1:0]        cur_step;
  logic [1:0]                    cur_sel;
  logic [PHASE_WIDTH-1:0]        addr_phase;
  logic signed [AMP_WIDTH-1:0]   s1_amp;

  logic [LUT_ADDR-1:0]           addr;
  logic [LUT_ADDR-1:0]           cos_addr;
  logic [LUT_ADDR-2:0]           tri_t;
  logic [DATA_WIDTH-1:0]         tri_v;
  logic signed [DATA_WIDTH-1:0]  wave;

  logic signed [PROD_W-1:0]      prod;
  logic signed [PROD_W-1:0]      prod_sh;
  logic signed [DATA_WIDTH-1:0]  scaled;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A configuration request takes priority over a run request.
        if (enh_conf_i)     state_d = ST_CONFI;
        else if (!en_low_i) state_d = ST_GEN;
      end
      ST_CONFI: state_d = ST_IDLE;
      ST_GEN:   if (en_low_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign in_gen = (state_q == ST_GEN);
  assign issue  = in_gen && !full_i;
  assign cfg_wr = (state_q == ST_CONFI);

  // -------------------------------------------------------------------------
  // Channel selected by the round-robin pointer
  // -------------------------------------------------------------------------
  always_comb begin : chan_select
    cur_phase = '0;
    cur_step  = '0;
    cur_sel   = '0;
    addr_phase = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(ptr_q) == c) begin
        cur_phase = phase_q[c];
        cur_step  = step_q[c];
        cur_sel   = sel_q[c];
`ifdef FGEN_PHASE_OFS_EN
        addr_phase = phase_q[c] + ofs_q[c];
`else
        addr_phase = phase_q[c];
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Configuration, phase accumulators and pointer
  // -------------------------------------------------------------------------
  always_comb begin : chan_next
    sel_d   = sel_q;
    amp_d   = amp_q;
    step_d  = step_q;
    phase_d = phase_q;
    ptr_d   = ptr_q;
`ifdef FGEN_PHASE_OFS_EN
    ofs_d   = ofs_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_wr && int'(ch_sel_i) == c) begin
        sel_d[c]  = sel_i;
        amp_d[c]  = amp_i;
        step_d[c] = step_i;
`ifdef FGEN_PHASE_OFS_EN
        ofs_d[c]  = phase_ofs_i;
`endif
      end
      if (!in_gen) begin
        phase_d[c] = '0;
      end else if (issue && int'(ptr_q) == c) begin
        phase_d[c] = cur_phase + cur_step;
      end
    end
    if (!in_gen) begin
      ptr_d = '0;
    end else if (issue) begin
      ptr_d = (int'(ptr_q) == NUM_CH - 1) ? '0 : ptr_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Waveform generation (address taken from the pre-increment phase)
  // -------------------------------------------------------------------------
  always_comb begin : wave_gen
    addr     = LUT_ADDR'(addr_phase >> (PHASE_WIDTH - LUT_ADDR));
    cos_addr = addr + QTR_ADDR;
    // Triangle folds the second half of the period back down.
    tri_t    = addr[LUT_ADDR-1] ? ~addr[LUT_ADDR-2:0] : addr[LUT_ADDR-2:0];
    tri_v    = (DATA_WIDTH'(tri_t) << (DATA_WIDTH - LUT_ADDR + 1)) - SIGN_BIT;
    case (cur_sel)
      2'd0:    wave = sine_lut[addr];
      2'd1:    wave = sine_lut[cos_addr];
      2'd2:    wave = tri_v;
      default: wave = addr[LUT_ADDR-1] ? WAVE_MIN : WAVE_MAX;
    endcase
  end

  // -------------------------------------------------------------------------
  // Scale with the amplitude of the channel held in S1, floor and saturate
  // -------------------------------------------------------------------------
  always_comb begin : scale
    s1_amp = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(s1_ch_q) == c) s1_amp = amp_q[c];
    end
    prod    = PROD_W'(s1_wave_q) * PROD_W'(s1_amp);
    prod_sh = prod >>> (AMP_WIDTH - 1);
    if (prod_sh > SAT_HI)      scaled = WAVE_MAX;
    else if (prod_sh < SAT_LO) scaled = WAVE_MIN;
    else                       scaled = prod_sh[DATA_WIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // Pipeline: cleared outside GEN, frozen while the FIFO is full
  // -------------------------------------------------------------------------
  always_comb begin : pipe_next
    s1_valid_d = s1_valid_q;
    s1_wave_d  = s1_wave_q;
    s1_ch_d    = s1_ch_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ch_d    = s2_ch_q;
    if (!in_gen) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (issue) begin
      s1_valid_d = 1'b1;
      s1_wave_d  = wave;
      s1_ch_d    = ptr_q;
      s2_valid_d = s1_valid_q;
      s2_data_d  = scaled;
      s2_ch_d    = s1_ch_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_wave_q  <= '0;
      s1_ch_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ch_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        phase_q[c] <= '0;
        sel_q[c]   <= '0;
        amp_q[c]   <= '0;
        step_q[c]  <= '0;
`ifdef FGEN_PHASE_OFS_EN
        ofs_q[c]   <= '0;
`endif
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_wave_q  <= s1_wave_d;
      s1_ch_q    <= s1_ch_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ch_q    <= s2_ch_d;
      phase_q    <= phase_d;
      sel_q      <= sel_d;
      amp_q      <= amp_d;
      step_q     <= step_d;
`ifdef FGEN_PHASE_OFS_EN
      ofs_q      <= ofs_d;
`endif
    end
  end

  // Gating with the state drops the strobe in the first IDLE cycle even
  // though S2 still holds the last in-flight sample at that point.
  assign wr_en_o = s2_valid_q && !full_i && in_gen;
  assign data_o  = s2_data_q;
  assign ch_o    = s2_ch_q;

endmodule

// File: tb/tb_funct_generator_nco.sv
// ---------------------------------------------------------------------------
// Testbench for funct_generator_nco: a single-channel instance (u_dut1) and
// a three-channel instance (u_dut3) share clock, reset and data inputs, with
// separate run/config strobes. Expected samples are computed by a reference
// model when a sample is issued and compared when wr_en_o is seen.
// ---------------------------------------------------------------------------
module tb_funct_generator_nco;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en_low   = 2'b11;
  logic [1:0]  enh_conf = 2'b00;
  logic [1:0]  ch_sel   = 2'd0;
  logic [1:0]  sel      = 2'd0;
  logic [7:0]  amp      = 8'd0;
  logic [15:0] step     = 16'd0;
  logic        full     = 1'b0;

  logic        wr_en1, wr_en3;
  logic [15:0] data1, data3;
  logic        ch1;
  logic [1:0]  ch3;

  int n_assert = 0;
  int n_fail   = 0;

  // model state, index 0 -> u_dut1, index 1 -> u_dut3
  int m_sel   [2][3];
  int m_amp   [2][3];
  int m_step  [2][3];
  int m_phase [2][3];
  int m_ptr   [2];

  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];

  funct_generator_nco #(.NUM_CH(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .en_low_i   (en_low[0]),
    .enh_conf_i (enh_conf[0]),
    .ch_sel_i   (ch_sel[0]),
    .sel_i      (sel),
    .amp_i      (amp),
    .step_i     (step),
`ifdef FGEN_PHASE_OFS_EN
    .phase_ofs_i(16'h0000),
`endif
    .full_i     (full),
    .wr_en_o    (wr_en1),
    .data_o     (data1),
    .ch_o       (ch1)
  );

  funct_generator_nco #(.NUM_CH(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .en_low_i   (en_low[1]),
    .enh_conf_i (enh_conf[1]),
    .ch_sel_i   (ch_sel),
    .sel_i      (sel),
    .amp_i      (amp),
    .step_i     (step),
`ifdef FGEN_PHASE_OFS_EN
    .phase_ofs_i(16'h0000),
`endif
    .full_i     (full),
    .wr_en_o    (wr_en3),
    .data_o     (data3),
    .ch_o       (ch3)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int nch(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int sine_ref(input int k);
    real r;
    r = 32767.0 * $sin(2.0 * PI * k / 256.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int wave_ref(input int s, input int phase);
    int a;
    a = (phase >> 8) & 255;
    case (s)
      0:       return sine_ref(a);
      1:       return sine_ref((a + 64) % 256);
      2:       return ((a >= 128) ? (255 - a) : a) * 512 - 32768;
      default: return (a < 128) ? 32767 : -32768;
    endcase
  endfunction

  function automatic int scale_ref(input int w, input int a);
    longint p;
    p = longint'(w) * longint'(a);
    p = p >>> 7;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  function automatic logic get_wr(input int d);
    return (d == 0) ? wr_en1 : wr_en3;
  endfunction

  function automatic logic [15:0] get_data(input int d);
    return (d == 0) ? data1 : data3;
  endfunction

  task automatic push_issue(input int d);
    int c, v;
    logic [17:0] ent;
    c = m_ptr[d];
    v = scale_ref(wave_ref(m_sel[d][c], m_phase[d][c]), m_amp[d][c]);
    ent = {2'(c), 16'(v)};
    if (d == 0) exp_q0.push_back(ent);
    else        exp_q1.push_back(ent);
    m_phase[d][c] = (m_phase[d][c] + m_step[d][c]) & 16'hFFFF;
    m_ptr[d] = (c + 1) % nch(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one configuration (strobe cycle in IDLE, then the CONFI cycle)
  task automatic cfg(input int d, input int c, input int s, input int a, input int st);
    enh_conf[d] = 1'b1;
    ch_sel = 2'(c);
    sel    = 2'(s);
    amp    = 8'(a);
    step   = 16'(st);
    tick();
    enh_conf[d] = 1'b0;
    tick();
    if (c < nch(d)) begin
      m_sel[d][c]  = s;
      m_amp[d][c]  = a;
      m_step[d][c] = st;
    end
  endtask

  // driver: a GEN run of 'cycles' cycles with an optional full_i window
  task automatic run(input int d, input int cycles, input int stall_at, input int stall_len);
    logic [17:0] fr;
    for (int c = 0; c < 3; c++) m_phase[d][c] = 0;
    m_ptr[d] = 0;
    en_low[d] = 1'b0;
    tick();
    for (int i = 1; i <= cycles; i++) begin
      full = (stall_len > 0) && (i >= stall_at) && (i < stall_at + stall_len);
      if (i == cycles) en_low[d] = 1'b1;
      if (!full) push_issue(d);
      #1;
      if (i <= 2) chk("first_wr_low", 32'(get_wr(d)), 32'd0);
      if (i == 3 && !full) chk("first_wr_high", 32'(get_wr(d)), 32'd1);
      if (full) begin
        fr = (d == 0) ? exp_q0[0] : exp_q1[0];
        chk("stall_wr", 32'(get_wr(d)), 32'd0);
        chk("stall_hold", 32'(get_data(d)), 32'(fr[15:0]));
      end
      @(posedge clk);
      #1;
    end
    full = 1'b0;
    chk("exit_wr", 32'(get_wr(d)), 32'd0);
    if (d == 0) begin
      chk("inflight_drop", 32'(exp_q0.size()), 32'd2);
      while (exp_q0.size() > 0) void'(exp_q0.pop_back());
    end else begin
      chk("inflight_drop", 32'(exp_q1.size()), 32'd2);
      while (exp_q1.size() > 0) void'(exp_q1.pop_back());
    end
  endtask

  // scoreboard
  always @(negedge clk) begin : scoreboard
    logic [17:0] e;
    if (!rst) begin
      if (wr_en1) begin
        if (exp_q0.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL dut1_unexpected: observed sample %0h expected none", data1);
        end else begin
          e = exp_q0.pop_front();
          chk("dut1_data", 32'(data1), 32'(e[15:0]));
          chk("dut1_ch", 32'(ch1), 32'(e[17:16]));
        end
      end
      if (wr_en3) begin
        if (exp_q1.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL dut3_unexpected: observed sample %0h expected none", data3);
        end else begin
          e = exp_q1.pop_front();
          chk("dut3_data", 32'(data3), 32'(e[15:0]));
          chk("dut3_ch", 32'(ch3), 32'(e[17:16]));
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0] st;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      for (int c = 0; c < 3; c++) begin
        m_sel[d][c] = 0; m_amp[d][c] = 0; m_step[d][c] = 0; m_phase[d][c] = 0;
      end
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wr1", 32'(wr_en1), 32'd0);
    chk("rst_data1", 32'(data1), 32'd0);
    chk("rst_wr3", 32'(wr_en3), 32'd0);
    chk("rst_data3", 32'(data3), 32'd0);
    chk("rst_ch3", 32'(ch3), 32'd0);
    st = u_dut3.state_q;
    chk("rst_state", 32'(st), 32'd0);

    // single channel square, 32511/32511/-32512/-32512
    cfg(0, 0, 3, 127, 16'h4000);
    run(0, 12, 0, 0);

    // same, with a three-cycle full window mid-stream
    run(0, 14, 7, 3);

    // triangle at phase 0 times -128 saturates to 32767
    cfg(0, 0, 2, -128, 0);
    run(0, 8, 0, 0);

    // three channels: sine@0, square half-rate, cosine with odd step
    cfg(1, 0, 0, 127, 0);
    cfg(1, 1, 3, 127, 16'h8000);
    cfg(1, 2, 1, 100, 16'h0D37);
    run(1, 24, 10, 2);

    // out-of-range channel with a simultaneous run request: CONFI wins,
    // nothing is written, then back to IDLE
    enh_conf[1] = 1'b1;
    en_low[1]   = 1'b0;
    ch_sel = 2'd3; sel = 2'd2; amp = 8'd5; step = 16'h1111;
    tick();
    st = u_dut3.state_q;
    chk("confi_prio", 32'(st), 32'd1);
    enh_conf[1] = 1'b0;
    en_low[1]   = 1'b1;
    tick();
    st = u_dut3.state_q;
    chk("confi_one_cycle", 32'(st), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("ignored_sel", 32'(u_dut3.sel_q[c]), 32'(m_sel[1][c]));
      chk("ignored_amp", 32'(u_dut3.amp_q[c]), 32'(m_amp[1][c]));
      chk("ignored_step", 32'(u_dut3.step_q[c]), 32'(m_step[1][c]));
    end
    run(1, 10, 0, 0);

    // asynchronous reset in the middle of a GEN run
    for (int c = 0; c < 3; c++) m_phase[1][c] = 0;
    m_ptr[1] = 0;
    en_low[1] = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      push_issue(1);
      if (i < 5) tick();
    end
    #1;
    chk("pre_rst_wr", 32'(wr_en3), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_wr", 32'(wr_en3), 32'd0);
    en_low[1] = 1'b1;
    exp_q1.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_data", 32'(data3), 32'd0);
    chk("post_rst_ch", 32'(ch3), 32'd0);
    chk("post_rst_wr", 32'(wr_en3), 32'd0);
    st = u_dut3.state_q;
    chk("post_rst_state", 32'(st), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("post_rst_phase", 32'(u_dut3.phase_q[c]), 32'd0);
      chk("post_rst_amp", 32'(u_dut3.amp_q[c]), 32'd0);
    end

    chk("q0_empty", 32'(exp_q0.size()), 32'd0);
    chk("q1_empty", 32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
